bsg_manycore_mmio_responder: RTL and testbench
==============================================

Name: bsg_manycore_mmio_responder

Overview:
Manycore-endpoint-side target for host-issued remote packets. Accepts decoded request packets from the host link endpoint, services loads, stores and atomics against a small word-addressed register file, and returns response packets to the requester. Sits at the opposite end of the host DPI initiator path; used as a bring-up and CSR target for host/manycore cosimulation.

Parameters:
data_width_p, 32, payload word width
addr_width_p, 28, EPA width of incoming request
x_cord_width_p, 7, requester X coordinate width
y_cord_width_p, 7, requester Y coordinate width
els_p, 16, register-file words (power of 2, >=2)
rsp_fifo_els_p, 2, response buffer depth (>=2)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
req_v_i  in  1  request valid
req_ready_o  out  1  request ready
req_op_i  in  2  0=load 1=store 2=amoswap 3=amoadd
req_addr_i  in  addr_width_p  word address
req_data_i  in  data_width_p  store/amo operand
req_mask_i  in  data_width_p/8  store byte mask
req_src_x_i  in  x_cord_width_p  requester X
req_src_y_i  in  y_cord_width_p  requester Y
req_tag_i  in  5  load id, echoed
rsp_v_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_data_o  out  data_width_p  load/amo old value, 0 for store
rsp_is_write_o  out  1  response is for store
rsp_err_o  out  1  address out of range
rsp_dst_x_o  out  x_cord_width_p  response destination X
rsp_dst_y_o  out  y_cord_width_p  response destination Y
rsp_tag_o  out  5  echoed tag
outstanding_o  out  $clog2(rsp_fifo_els_p+1)  buffered responses

Behaviour:
- Reset (reset_n_i low, async assert, sync-deassert assumed upstream): register file all 0, FIFO empty, rsp_v_o=0, req_ready_o=0 while in reset, outstanding_o=0.
- States: RESET -> INIT (one cycle, clears nothing further, req_ready_o=0) -> RUN. Reset mid-operation drops all buffered responses; no response for in-flight requests.
- RUN: req_ready_o = ~fifo_full | (rsp_v_o & rsp_ready_i) (pass-through on simultaneous dequeue). Handshake fires on req_v_i & req_ready_o.
- In-range: req_addr_i < els_p; index = req_addr_i[$clog2(els_p)-1:0]. Out-of-range: no RF update, rsp_err_o=1, rsp_data_o=0.
- load: rsp_data = rf[idx]. store: rf[idx] byte-merged by req_mask_i, rsp_data=0, rsp_is_write=1. amoswap: rsp_data=old, rf=req_data_i. amoadd: rsp_data=old, rf=old+req_data_i mod 2^data_width_p (wrap, no flag).
- RF update and FIFO enqueue in accept cycle; response visible on rsp_v_o next cycle (latency 1). Back-to-back same-address requests see previous write (RAW forwarding inherent since RF updated at accept edge).
- FIFO full and no dequeue: req_ready_o=0, RF untouched. Empty: rsp_v_o=0, outputs hold last value (don't-care).
- outstanding_o = FIFO occupancy; +1 on enqueue, -1 on dequeue, unchanged on both.

Decomposition:
- Package bsg_manycore_mmio_pkg: op enum (e_mmio_load/store/amoswap/amoadd), response struct {data, is_write, err, dst_x, dst_y, tag}.
- Sub-module: bsg_manycore_mmio_rsp_fifo (els rsp_fifo_els_p, ready/valid both sides, count output); RF, decode and FSM stay in top.

Test Plan:
- Reset then store addr 3 data 0xCAFEF00D mask 0xF, load addr 3 tag 7 -> store rsp is_write=1 data 0; load rsp data 0xCAFEF00D tag 7, dst matches src.
- Store mask 0x2 data 0x0000AB00 to word holding 0x11223344 -> subsequent load returns 0x1122AB44.
- amoadd 0xFFFFFFFF operand 2 -> rsp 0xFFFFFFFF, next load returns 0x00000001; amoswap 5 -> rsp 1, load 5.
- Load addr els_p (16) -> rsp_err_o=1, data 0, RF unchanged.
- Hold rsp_ready_i=0, issue 3 requests -> 2 accepted, req_ready_o=0, outstanding_o=2; raise rsp_ready_i with req_v_i high -> simultaneous deq/enq, outstanding stays 2, order preserved.
- Assert reset_n_i low with 2 buffered responses -> rsp_v_o=0 immediately, outstanding_o=0, loads after reset return 0.

Source files
------------

// File: rtl/bsg_manycore_mmio_pkg.sv
// Shared types for the manycore MMIO responder: request opcodes and the
// response record layout.
package bsg_manycore_mmio_pkg;

    localparam int unsigned mmio_tag_width_lp = 5;

    typedef enum logic [1:0] {
        e_mmio_load    = 2'd0,
        e_mmio_store   = 2'd1,
        e_mmio_amoswap = 2'd2,
        e_mmio_amoadd  = 2'd3
    } mmio_op_e;

    // Field order for the default widths; the top re-declares it with its own widths.
    typedef struct packed {
        logic [31:0]                  data;
        logic                         is_write;
        logic                         err;
        logic [6:0]                   dst_x;
        logic [6:0]                   dst_y;
        logic [mmio_tag_width_lp-1:0] tag;
    } mmio_rsp_s;

endpackage

// File: rtl/bsg_manycore_mmio_rsp_fifo.sv
// Ready/valid response buffer with occupancy count; a full buffer still
// accepts an entry in the same cycle it releases one.
module bsg_manycore_mmio_rsp_fifo #(
    parameter int unsigned width_p = 53,
    parameter int unsigned els_p   = 2,
    localparam int unsigned cnt_width_lp = $clog2(els_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    enq_v_i,
    output logic                    enq_ready_o,
    input  logic [width_p-1:0]      enq_data_i,
    output logic                    deq_v_o,
    input  logic                    deq_ready_i,
    output logic [width_p-1:0]      deq_data_o,
    output logic [cnt_width_lp-1:0] count_o
);

    localparam int unsigned ptr_width_lp = $clog2(els_p);

    logic [width_p-1:0]      mem_q [els_p];
    logic [ptr_width_lp-1:0] rptr_q, wptr_q;
    logic [cnt_width_lp-1:0] count_q;
    logic                    full, enq_fire, deq_fire;

    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full        = (count_q == cnt_width_lp'(els_p));
    assign deq_v_o     = (count_q != '0);
    assign enq_ready_o = ~full | deq_ready_i;
    assign enq_fire    = enq_v_i & enq_ready_o;
    assign deq_fire    = deq_v_o & deq_ready_i;
    assign deq_data_o  = mem_q[rptr_q];
    assign count_o     = count_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire) wptr_q <= next_ptr(wptr_q);
            if (deq_fire) rptr_q <= next_ptr(rptr_q);
            case ({enq_fire, deq_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_fire) mem_q[wptr_q] <= enq_data_i;
    end

endmodule

// File: rtl/bsg_manycore_mmio_responder.sv
// Host-facing MMIO target: services load/store/amo requests against a small
// word-addressed register file and returns responses through a small buffer.
module bsg_manycore_mmio_responder
    import bsg_manycore_mmio_pkg::*;
#(
    parameter int unsigned data_width_p   = 32,
    parameter int unsigned addr_width_p   = 28,
    parameter int unsigned x_cord_width_p = 7,
    parameter int unsigned y_cord_width_p = 7,
    parameter int unsigned els_p          = 16,
    parameter int unsigned rsp_fifo_els_p = 2,
    localparam int unsigned cnt_width_lp  = $clog2(rsp_fifo_els_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        req_v_i,
    output logic                        req_ready_o,
    input  logic [1:0]                  req_op_i,
    input  logic [addr_width_p-1:0]     req_addr_i,
    input  logic [data_width_p-1:0]     req_data_i,
    input  logic [data_width_p/8-1:0]   req_mask_i,
    input  logic [x_cord_width_p-1:0]   req_src_x_i,
    input  logic [y_cord_width_p-1:0]   req_src_y_i,
    input  logic [4:0]                  req_tag_i,
    output logic                        rsp_v_o,
    input  logic                        rsp_ready_i,
    output logic [data_width_p-1:0]     rsp_data_o,
    output logic                        rsp_is_write_o,
    output logic                        rsp_err_o,
    output logic [x_cord_width_p-1:0]   rsp_dst_x_o,
    output logic [y_cord_width_p-1:0]   rsp_dst_y_o,
    output logic [4:0]                  rsp_tag_o,
    output logic [cnt_width_lp-1:0]     outstanding_o
);

    localparam int unsigned idx_width_lp = $clog2(els_p);
    localparam int unsigned bytes_lp     = data_width_p / 8;

    typedef struct packed {
        logic [data_width_p-1:0]      data;
        logic                         is_write;
        logic                         err;
        logic [x_cord_width_p-1:0]    dst_x;
        logic [y_cord_width_p-1:0]    dst_y;
        logic [mmio_tag_width_lp-1:0] tag;
    } rsp_s;

    typedef enum logic [1:0] {StReset, StInit, StRun} state_e;

    state_e                  state_q;
    logic [data_width_p-1:0] rf_q [els_p];
    logic [idx_width_lp-1:0] idx;
    logic [data_width_p-1:0] old_data, wdata;
    logic                    in_range, req_fire, rf_we, fifo_enq_ready;
    mmio_op_e                op;
    rsp_s                    enq_rsp, deq_rsp;

    assign op       = mmio_op_e'(req_op_i);
    assign idx      = req_addr_i[idx_width_lp-1:0];
    assign in_range = ((req_addr_i >> idx_width_lp) == '0);
    assign old_data = rf_q[idx];

    assign req_ready_o = (state_q == StRun) & fifo_enq_ready;
    assign req_fire    = req_v_i & req_ready_o;
    assign rf_we       = req_fire & in_range & (op != e_mmio_load);

    always_comb begin
        wdata = old_data;
        case (op)
            e_mmio_store: begin
                for (int b = 0; b < bytes_lp; b++) begin
                    if (req_mask_i[b]) wdata[8*b +: 8] = req_data_i[8*b +: 8];
                end
            end
            e_mmio_amoswap: wdata = req_data_i;
            e_mmio_amoadd:  wdata = old_data + req_data_i;
            default:        wdata = old_data;
        endcase
    end

    always_comb begin
        enq_rsp          = '0;
        enq_rsp.data     = (in_range && op != e_mmio_store) ? old_data : '0;
        enq_rsp.is_write = (op == e_mmio_store);
        enq_rsp.err      = ~in_range;
        enq_rsp.dst_x    = req_src_x_i;
        enq_rsp.dst_y    = req_src_y_i;
        enq_rsp.tag      = req_tag_i;
    end

    // Two-cycle bring-up after reset release before requests are taken.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StReset;
            for (int i = 0; i < els_p; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                StReset: state_q <= StInit;
                StInit:  state_q <= StRun;
                StRun:   state_q <= StRun;
                default: state_q <= StReset;
            endcase
            if (rf_we) rf_q[idx] <= wdata;
        end
    end

    bsg_manycore_mmio_rsp_fifo #(
        .width_p ($bits(rsp_s)),
        .els_p   (rsp_fifo_els_p)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .enq_v_i     (req_fire),
        .enq_ready_o (fifo_enq_ready),
        .enq_data_i  (enq_rsp),
        .deq_v_o     (rsp_v_o),
        .deq_ready_i (rsp_ready_i),
        .deq_data_o  (deq_rsp),
        .count_o     (outstanding_o)
    );

    assign rsp_data_o     = deq_rsp.data;
    assign rsp_is_write_o = deq_rsp.is_write;
    assign rsp_err_o      = deq_rsp.err;
    assign rsp_dst_x_o    = deq_rsp.dst_x;
    assign rsp_dst_y_o    = deq_rsp.dst_y;
    assign rsp_tag_o      = deq_rsp.tag;

endmodule

// File: tb/tb_bsg_manycore_mmio_responder.sv
// Randomised scoreboard bench for the MMIO responder against a simple
// array-based register-file model.
module tb_bsg_manycore_mmio_responder;

    localparam int RW = 32 + 1 + 1 + 7 + 7 + 5;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b1;
    logic        req_v_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_op_i = '0;
    logic [27:0] req_addr_i = '0;
    logic [31:0] req_data_i = '0;
    logic [3:0]  req_mask_i = '0;
    logic [6:0]  req_src_x_i = '0;
    logic [6:0]  req_src_y_i = '0;
    logic [4:0]  req_tag_i = '0;
    logic        rsp_v_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_is_write_o;
    logic        rsp_err_o;
    logic [6:0]  rsp_dst_x_o;
    logic [6:0]  rsp_dst_y_o;
    logic [4:0]  rsp_tag_o;
    logic [1:0]  outstanding_o;

    int          n_pass = 0;
    int          n_total = 0;
    int          ready_mode = 0;  // 0: hold low, 1: always high, 2: random
    logic [31:0] model_rf [16];
    logic [RW-1:0] exp_q [$];

    bsg_manycore_mmio_responder dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n_i),
        .req_v_i        (req_v_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_addr_i     (req_addr_i),
        .req_data_i     (req_data_i),
        .req_mask_i     (req_mask_i),
        .req_src_x_i    (req_src_x_i),
        .req_src_y_i    (req_src_y_i),
        .req_tag_i      (req_tag_i),
        .rsp_v_o        (rsp_v_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_data_o     (rsp_data_o),
        .rsp_is_write_o (rsp_is_write_o),
        .rsp_err_o      (rsp_err_o),
        .rsp_dst_x_o    (rsp_dst_x_o),
        .rsp_dst_y_o    (rsp_dst_y_o),
        .rsp_tag_o      (rsp_tag_o),
        .outstanding_o  (outstanding_o)
    );

    always #5 clk = ~clk;

    initial begin
        rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       rsp_ready_i = 1'b0;
                1:       rsp_ready_i = 1'b1;
                default: rsp_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference behaviour: returns the expected response and updates the model.
    function automatic logic [RW-1:0] model_req(input logic [1:0] op, input logic [27:0] addr,
                                                input logic [31:0] data, input logic [3:0] mask,
                                                input logic [6:0] x, input logic [6:0] y,
                                                input logic [4:0] tag);
        logic [31:0] old, rd;
        logic        err;
        int          i;
        err = (addr >= 28'd16);
        rd  = '0;
        if (!err) begin
            i   = int'(addr);
            old = model_rf[i];
            case (op)
                2'd0: rd = old;
                2'd1: for (int b = 0; b < 4; b++) if (mask[b]) model_rf[i][8*b +: 8] = data[8*b +: 8];
                2'd2: begin rd = old; model_rf[i] = data; end
                default: begin rd = old; model_rf[i] = old + data; end
            endcase
        end
        return {rd, (op == 2'd1), err, x, y, tag};
    endfunction

    function automatic void push_current();
        exp_q.push_back(model_req(req_op_i, req_addr_i, req_data_i, req_mask_i,
                                  req_src_x_i, req_src_y_i, req_tag_i));
    endfunction

    task automatic drive(input logic [1:0] op, input logic [27:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [4:0] tag);
        req_op_i    = op;
        req_addr_i  = addr;
        req_data_i  = data;
        req_mask_i  = mask;
        req_tag_i   = tag;
        req_src_x_i = 7'($urandom);
        req_src_y_i = 7'($urandom);
        req_v_i     = 1'b1;
    endtask

    // Entered and left just after a rising edge.
    task automatic send(input logic [1:0] op, input logic [27:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [4:0] tag);
        int waited;
        drive(op, addr, data, mask, tag);
        waited = 0;
        @(negedge clk);
        while (!req_ready_o && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready_o) begin
            check("req_accept_timeout", 64'(req_ready_o), 64'd1);
            @(posedge clk);
        end else begin
            push_current();
            @(posedge clk);
        end
        #1 req_v_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        #1;
        check("reset_rsp_v", 64'(rsp_v_o), 64'd0);
        check("reset_outstanding", 64'(outstanding_o), 64'd0);
        check("reset_req_ready", 64'(req_ready_o), 64'd0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) model_rf[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n_i = 1'b1;
        @(posedge clk);
        @(negedge clk) check("init_req_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk);
        @(negedge clk) check("run_req_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waited;
        ready_mode = 1;
        waited = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || rsp_v_o) && waited < 500) begin
            waited++;
            @(negedge clk);
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n_i && rsp_v_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_v_o), 64'd0);
            end else begin
                check("rsp", 64'({rsp_data_o, rsp_is_write_o, rsp_err_o, rsp_dst_x_o,
                                  rsp_dst_y_o, rsp_tag_o}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        ready_mode = 1;

        send(2'd1, 28'd3, 32'hCAFEF00D, 4'hF, 5'd1);
        send(2'd0, 28'd3, 32'h0, 4'h0, 5'd7);
        send(2'd1, 28'd5, 32'h11223344, 4'hF, 5'd2);
        send(2'd1, 28'd5, 32'h0000AB00, 4'h2, 5'd3);
        send(2'd0, 28'd5, 32'h0, 4'h0, 5'd4);
        send(2'd1, 28'd6, 32'hFFFFFFFF, 4'hF, 5'd5);
        send(2'd3, 28'd6, 32'd2, 4'h0, 5'd6);
        send(2'd0, 28'd6, 32'h0, 4'h0, 5'd8);
        send(2'd2, 28'd6, 32'd5, 4'h0, 5'd9);
        send(2'd0, 28'd6, 32'h0, 4'h0, 5'd10);
        send(2'd0, 28'd16, 32'h0, 4'h0, 5'd11);
        send(2'd1, 28'd19, 32'hDEADBEEF, 4'hF, 5'd12);
        send(2'd3, 28'h0FFFFFF, 32'd1, 4'h0, 5'd13);
        send(2'd0, 28'd3, 32'h0, 4'h0, 5'd14);
        drain();

        // Backpressure: two fill the buffer, the third waits for a dequeue.
        ready_mode = 0;
        send(2'd0, 28'd3, 32'h0, 4'h0, 5'd20);
        send(2'd2, 28'd7, 32'h12345678, 4'h0, 5'd21);
        drive(2'd0, 28'd7, 32'h0, 4'h0, 5'd22);
        @(negedge clk);
        check("full_req_ready", 64'(req_ready_o), 64'd0);
        check("full_outstanding", 64'(outstanding_o), 64'd2);
        check("full_rsp_v", 64'(rsp_v_o), 64'd1);
        @(posedge clk);
        #1 ready_mode = 1;
        @(negedge clk);
        check("passthru_req_ready", 64'(req_ready_o), 64'd1);
        if (req_ready_o) push_current();
        @(posedge clk);
        #1 req_v_i = 1'b0;
        @(negedge clk);
        check("passthru_outstanding", 64'(outstanding_o), 64'd2);
        @(posedge clk);
        #1;
        drain();

        // Reset with responses still buffered.
        ready_mode = 0;
        send(2'd0, 28'd3, 32'h0, 4'h0, 5'd23);
        send(2'd0, 28'd5, 32'h0, 4'h0, 5'd24);
        @(negedge clk);
        check("prereset_outstanding", 64'(outstanding_o), 64'd2);
        do_reset();
        ready_mode = 1;
        send(2'd0, 28'd3, 32'h0, 4'h0, 5'd25);
        send(2'd0, 28'd5, 32'h0, 4'h0, 5'd26);
        send(2'd0, 28'd6, 32'h0, 4'h0, 5'd27);
        drain();

        ready_mode = 2;
        for (int n = 0; n < 300; n++) begin
            send(2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0) ? 28'($urandom) : 28'($urandom_range(0, 15)),
                 $urandom, 4'($urandom), 5'($urandom));
        end
        drain();
        @(negedge clk);
        check("final_outstanding", 64'(outstanding_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
